// File: rtl/sw_debounce.sv
// sw_debounce: synchronizes a bouncing slide switch and qualifies each level
// change over STABLE_CYCLES consecutive samples before moving SW_DB.
module sw_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW,
    output logic SW_DB,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);
    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam bit SINGLE = (STABLE_CYCLES == 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             sw_db_q, sw_db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            STABLE_LO: if (s2_q) begin
                state_d = SINGLE ? STABLE_HI : WAIT_HI;
                cnt_d   = SINGLE ? '0 : ONE_CNT;
            end
            WAIT_HI: begin
                if (!s2_q) state_d = STABLE_LO;
                else if (cnt_q == LAST) state_d = STABLE_HI;
                else cnt_d = cnt_q + ONE_CNT;
            end
            STABLE_HI: if (!s2_q) begin
                state_d = SINGLE ? STABLE_LO : WAIT_LO;
                cnt_d   = SINGLE ? '0 : ONE_CNT;
            end
            WAIT_LO: begin
                if (s2_q) state_d = STABLE_HI;
                else if (cnt_q == LAST) state_d = STABLE_LO;
                else cnt_d = cnt_q + ONE_CNT;
            end
        endcase
        // Outputs are decoded from the next state so they land with it.
        sw_db_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        rise_d  = sw_db_d && !sw_db_q;
        fall_d  = !sw_db_d && sw_db_q;
        busy_d  = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            sw_db_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= SW;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_db_q <= sw_db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign SW_DB = sw_db_q;
    assign RISE  = rise_q;
    assign FALL  = fall_q;
    assign BUSY  = busy_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios for sw_debounce at STABLE_CYCLES=4 and 1.
module tb_sw_debounce;
    logic CLK = 1'b0, RST = 1'b1, SW = 1'b0, SW1 = 1'b0;
    logic sw_db, rise, fall, busy, sw_db1, rise1, fall1, busy1;
    logic [3:0] exp_v;
    int vec = 0, errs = 0;

    always #5 CLK = ~CLK;

    sw_debounce #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .SW(SW),
        .SW_DB(sw_db), .RISE(rise), .FALL(fall), .BUSY(busy)
    );

    sw_debounce #(.STABLE_CYCLES(1), .CNT_W(2)) dut1 (
        .CLK(CLK), .RST(RST), .SW(SW1),
        .SW_DB(sw_db1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vec++;
        if ({sw_db, rise, fall, busy, sw_db1, rise1, fall1, busy1} !== 8'h00) begin
            errs++;
            $display("FAIL reset_async: got %b want 00000000", {sw_db, rise, fall, busy, sw_db1, rise1, fall1, busy1});
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int e = 0; e < 3; e++) tick();
        vec++;
        if ({sw_db, rise, fall, busy} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_idle: got %b want 0000", {sw_db, rise, fall, busy});
        end
    endtask

    task automatic test_clean_step();
        SW = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_v = {e >= 5, e == 5, 1'b0, e >= 2 && e <= 4};
            vec++;
            if ({sw_db, rise, fall, busy} !== exp_v) begin
                errs++;
                $display("FAIL clean_step edge %0d: got %b want %b", e, {sw_db, rise, fall, busy}, exp_v);
            end
        end
    endtask

    task automatic test_release();
        SW = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            exp_v = {e < 5, 1'b0, e == 5, e >= 2 && e <= 4};
            vec++;
            if ({sw_db, rise, fall, busy} !== exp_v) begin
                errs++;
                $display("FAIL release edge %0d: got %b want %b", e, {sw_db, rise, fall, busy}, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        SW = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            tick();
            if (e == 2) SW = 1'b0;
            exp_v = {1'b0, 1'b0, 1'b0, e >= 2 && e <= 4};
            vec++;
            if ({sw_db, rise, fall, busy} !== exp_v) begin
                errs++;
                $display("FAIL glitch edge %0d: got %b want %b", e, {sw_db, rise, fall, busy}, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        SW = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            tick();
            if (e < 4) SW = e[0];
            rises += int'(rise);
            exp_v = {e >= 9, e == 9, 1'b0, e == 2 || e == 4 || (e >= 6 && e <= 8)};
            vec++;
            if ({sw_db, rise, fall, busy} !== exp_v) begin
                errs++;
                $display("FAIL bounce edge %0d: got %b want %b", e, {sw_db, rise, fall, busy}, exp_v);
            end
        end
        vec++;
        if (rises != 1) begin
            errs++;
            $display("FAIL bounce_rise_count: got %0d want 1", rises);
        end
    endtask

    task automatic test_reset_mid();
        SW = 1'b1;
        for (int e = 0; e <= 3; e++) tick();
        vec++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid_busy_before: got %b want 1", busy);
        end
        RST = 1'b1;
        #1;
        vec++;
        if ({sw_db, rise, fall, busy} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_mid_async: got %b want 0000", {sw_db, rise, fall, busy});
        end
        #3;
        RST = 1'b0;
        for (int r = 0; r <= 6; r++) begin
            tick();
            exp_v = {r >= 5, r == 5, 1'b0, r >= 2 && r <= 4};
            vec++;
            if ({sw_db, rise, fall, busy} !== exp_v) begin
                errs++;
                $display("FAIL reset_mid edge %0d: got %b want %b", r, {sw_db, rise, fall, busy}, exp_v);
            end
        end
    endtask

    task automatic test_long_hold();
        int rises = 0, falls = 0, drops = 0, max_cnt = 0;
        bit seen = 1'b0;
        SW = 1'b0;
        for (int e = 0; e < 8; e++) tick();
        vec++;
        if (sw_db !== 1'b0) begin
            errs++;
            $display("FAIL long_hold_pre: got %b want 0", sw_db);
        end
        SW = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            rises += int'(rise);
            falls += int'(fall);
            if (seen && sw_db !== 1'b1) drops++;
            if (sw_db === 1'b1) seen = 1'b1;
            if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
        end
        vec++;
        if (rises != 1 || falls != 0 || drops != 0 || !seen) begin
            errs++;
            $display("FAIL long_hold: rises %0d falls %0d drops %0d seen %0b want 1 0 0 1", rises, falls, drops, seen);
        end
        vec++;
        if (max_cnt > 3) begin
            errs++;
            $display("FAIL long_hold_cnt: max %0d want <=3", max_cnt);
        end
        vec++;
        if ({sw_db, rise, fall, busy} !== 4'b1000) begin
            errs++;
            $display("FAIL long_hold_end: got %b want 1000", {sw_db, rise, fall, busy});
        end
    endtask

    task automatic test_single_cycle();
        SW1 = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            exp_v = {e >= 2, e == 2, 1'b0, 1'b0};
            vec++;
            if ({sw_db1, rise1, fall1, busy1} !== exp_v) begin
                errs++;
                $display("FAIL single_rise edge %0d: got %b want %b", e, {sw_db1, rise1, fall1, busy1}, exp_v);
            end
        end
        SW1 = 1'b0;
        for (int e = 4; e <= 9; e++) begin
            tick();
            if (e == 4) SW1 = 1'b1;
            exp_v = {e != 6, e == 7, e == 6, 1'b0};
            vec++;
            if ({sw_db1, rise1, fall1, busy1} !== exp_v) begin
                errs++;
                $display("FAIL single_pulse edge %0d: got %b want %b", e, {sw_db1, rise1, fall1, busy1}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_release();
        test_glitch();
        test_bounce();
        test_release();
        test_reset_mid();
        test_long_hold();
        test_single_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
